// File: rtl/signal_lamp_monitor_if.sv
// ---------------------------------------------------------------------------
// signal_lamp_monitor_if
// Bundles the signals between the traffic state machine / operator panel and
// the lamp safety monitor.
//   tick         1-second pulse, one clock wide
//   road1_in     road 1 light code (RED=001, YELLOW=010, GREEN=100)
//   road2_in     road 2 light code
//   clear_fault  one-cycle operator clear request
//   lamp1/lamp2  lamp drive codes
//   fault        high while the monitor is in FAULT or RECOVER
//   fault_code   latched cause: 0 none, 1 ILLEGAL, 2 CONFLICT, 3 BAD_SEQ,
//                4 STUCK
//   fault_count  saturating count of fault entries (only when the macro
//                FAULT_COUNT_EN is defined)
// Modports: master = the side that drives the inputs and reads the lamps,
//           slave  = the monitor itself.
// ---------------------------------------------------------------------------
interface signal_lamp_monitor_if;
  logic       tick;
  logic [2:0] road1_in;
  logic [2:0] road2_in;
  logic       clear_fault;
  logic [2:0] lamp1;
  logic [2:0] lamp2;
  logic       fault;
  logic [2:0] fault_code;
`ifdef FAULT_COUNT_EN
  logic [7:0] fault_count;

  modport master (
    output tick, road1_in, road2_in, clear_fault,
    input  lamp1, lamp2, fault, fault_code, fault_count
  );

  modport slave (
    input  tick, road1_in, road2_in, clear_fault,
    output lamp1, lamp2, fault, fault_code, fault_count
  );
`else
  modport master (
    output tick, road1_in, road2_in, clear_fault,
    input  lamp1, lamp2, fault, fault_code
  );

  modport slave (
    input  tick, road1_in, road2_in, clear_fault,
    output lamp1, lamp2, fault, fault_code
  );
`endif
endinterface

// File: rtl/signal_lamp_monitor.sv
// ---------------------------------------------------------------------------
// signal_lamp_monitor
// Sits between the traffic state machine and the lamp drivers. Every light
// change is checked for legality; legal codes are forwarded to the lamps with
// a two-cycle latency (input register + output register). On a violation the
// monitor latches the cause, flashes red on both roads, and only returns to
// normal service after an operator clear followed by HOLD_TICKS consecutive
// all-red ticks.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous, active-low reset
//   mon    signal_lamp_monitor_if.slave (tick, road codes, clear request in;
//          lamp drives, fault, fault_code [, fault_count] out)
//
// Parameters:
//   MAX_DWELL   ticks a road may stay non-red without change before STUCK
//   DWELL_W     dwell counter width (must hold MAX_DWELL)
//   HOLD_TICKS  consecutive all-red ticks needed to leave RECOVER
//
// Optional feature: define FAULT_COUNT_EN to add the saturating 8-bit
// fault_count output (counts NORMAL->FAULT entries, cleared only by rst_n).
// ---------------------------------------------------------------------------
module signal_lamp_monitor #(
  parameter int MAX_DWELL  = 15,
  parameter int DWELL_W    = 5,
  parameter int HOLD_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  signal_lamp_monitor_if.slave  mon
);

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b100;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
  localparam logic [2:0] CODE_CONFLICT = 3'd2;
  localparam logic [2:0] CODE_BAD_SEQ  = 3'd3;
  localparam logic [2:0] CODE_STUCK    = 3'd4;

  localparam logic [1:0] ST_NORMAL  = 2'd0;
  localparam logic [1:0] ST_FAULT   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  // +2 keeps the width at least one bit even for HOLD_TICKS = 0
  localparam int HOLD_W = $clog2(HOLD_TICKS + 2);

  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MAX_DWELL);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_TICKS);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [2:0]         cur1_reg,   cur1_next;
  logic [2:0]         cur2_reg,   cur2_next;
  logic [2:0]         prev1_reg,  prev1_next;
  logic [2:0]         prev2_reg,  prev2_next;
  logic [1:0]         state_reg,  state_next;
  logic [DWELL_W-1:0] dwell_reg,  dwell_next;
  logic [HOLD_W-1:0]  hold_reg,   hold_next;
  logic               blink_reg,  blink_next;
  logic [2:0]         lamp1_reg,  lamp1_next;
  logic [2:0]         lamp2_reg,  lamp2_next;
  logic               fault_reg,  fault_next;
  logic [2:0]         code_reg,   code_next;

  // -------------------------------------------------------------------------
  // Rule helpers
  // -------------------------------------------------------------------------
  function automatic logic is_legal(input logic [2:0] c);
    return (c == RED) || (c == YELLOW) || (c == GREEN);
  endfunction

  // Only the two jumps that skip yellow are forbidden; everything else
  // between legal codes (including no change) is allowed.
  function automatic logic is_bad_step(input logic [2:0] p, input logic [2:0] c);
    return ((p == RED) && (c == GREEN)) || ((p == GREEN) && (c == RED));
  endfunction

  logic       illegal;
  logic       conflict;
  logic       bad_seq;
  logic       stuck;
  logic       both_red;
  logic       changed;
  logic [2:0] viol_code;
  logic       enter_fault;

  always_comb begin
    both_red = (cur1_reg == RED) && (cur2_reg == RED);
    changed  = (cur1_reg != prev1_reg) || (cur2_reg != prev2_reg);
    illegal  = !is_legal(cur1_reg) || !is_legal(cur2_reg);
    conflict = (cur1_reg != RED) && (cur2_reg != RED);
    bad_seq  = is_bad_step(prev1_reg, cur1_reg) || is_bad_step(prev2_reg, cur2_reg);
    stuck    = !both_red && (dwell_reg == DWELL_MAX);

    // Highest-priority cause wins; lower ones are discarded.
    if (illegal)       viol_code = CODE_ILLEGAL;
    else if (conflict) viol_code = CODE_CONFLICT;
    else if (bad_seq)  viol_code = CODE_BAD_SEQ;
    else if (stuck)    viol_code = CODE_STUCK;
    else               viol_code = CODE_NONE;

    enter_fault = (state_reg == ST_NORMAL) && (viol_code != CODE_NONE);
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    cur1_next  = mon.road1_in;
    cur2_next  = mon.road2_in;
    prev1_next = cur1_reg;
    prev2_next = cur2_reg;
    state_next = state_reg;
    dwell_next = dwell_reg;
    hold_next  = hold_reg;
    blink_next = blink_reg;
    fault_next = fault_reg;
    code_next  = code_reg;
    lamp1_next = lamp1_reg;
    lamp2_next = lamp2_reg;

    case (state_reg)
      ST_NORMAL: begin
        if (enter_fault) begin
          state_next = ST_FAULT;
          fault_next = 1'b1;
          code_next  = viol_code;
          blink_next = 1'b1;
          dwell_next = '0;
        end else if (changed || both_red) begin
          // a change wins over a tick arriving in the same cycle
          dwell_next = '0;
        end else if (mon.tick && (dwell_reg != DWELL_MAX)) begin
          dwell_next = dwell_reg + 1'b1;
        end
      end

      ST_FAULT: begin
        if (mon.tick) begin
          blink_next = ~blink_reg;
        end
        if (mon.clear_fault) begin
          state_next = ST_RECOVER;
          hold_next  = '0;
        end
      end

      ST_RECOVER: begin
        if (hold_reg == HOLD_MAX) begin
          state_next = ST_NORMAL;
          fault_next = 1'b0;
          code_next  = CODE_NONE;
          dwell_next = '0;
        end else if (!both_red) begin
          hold_next = '0;
        end else if (mon.tick) begin
          hold_next = hold_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_NORMAL;
        fault_next = 1'b0;
        code_next  = CODE_NONE;
      end
    endcase

    // Lamps follow the state being entered so that the fault display
    // changes on the very edge the fault is latched.
    case (state_next)
      ST_NORMAL: begin
        lamp1_next = cur1_reg;
        lamp2_next = cur2_reg;
      end
      ST_FAULT: begin
        lamp1_next = {2'b00, blink_next};
        lamp2_next = {2'b00, blink_next};
      end
      default: begin
        lamp1_next = RED;
        lamp2_next = RED;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur1_reg  <= RED;
      cur2_reg  <= RED;
      prev1_reg <= RED;
      prev2_reg <= RED;
      state_reg <= ST_NORMAL;
      dwell_reg <= '0;
      hold_reg  <= '0;
      blink_reg <= 1'b1;
      lamp1_reg <= RED;
      lamp2_reg <= RED;
      fault_reg <= 1'b0;
      code_reg  <= CODE_NONE;
    end else begin
      cur1_reg  <= cur1_next;
      cur2_reg  <= cur2_next;
      prev1_reg <= prev1_next;
      prev2_reg <= prev2_next;
      state_reg <= state_next;
      dwell_reg <= dwell_next;
      hold_reg  <= hold_next;
      blink_reg <= blink_next;
      lamp1_reg <= lamp1_next;
      lamp2_reg <= lamp2_next;
      fault_reg <= fault_next;
      code_reg  <= code_next;
    end
  end

  assign mon.lamp1      = lamp1_reg;
  assign mon.lamp2      = lamp2_reg;
  assign mon.fault      = fault_reg;
  assign mon.fault_code = code_reg;

`ifdef FAULT_COUNT_EN
  // -------------------------------------------------------------------------
  // Fault entry counter: survives recovery, cleared only by reset.
  // -------------------------------------------------------------------------
  logic [7:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (enter_fault && (count_reg != 8'hFF)) begin
      count_next = count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 8'd0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign mon.fault_count = count_reg;
`endif

endmodule

// File: doc/signal_lamp_monitor.md
Name: signal_lamp_monitor

Overview:
- Sits directly downstream of the traffic state machine.
- Consumes road1/road2 light codes (RED=3'b001, YELLOW=3'b010, GREEN=3'b100) and the 1-second tick.
- Checks every light change for legality and forwards the codes to the lamp drivers.
- On a safety violation it latches a fault, forces flashing red on both roads, and releases only after an operator clear plus a sustained all-red period.

Parameters:
- MAX_DWELL, 15, max ticks any road may stay non-red without a change before a STUCK fault.
- DWELL_W, 5, width of the dwell counter; must hold MAX_DWELL.
- HOLD_TICKS, 3, consecutive all-red ticks required in RECOVER before returning to NORMAL.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle 1-second pulse.
- road1_in  input  3  road 1 light code from the state machine.
- road2_in  input  3  road 2 light code from the state machine.
- clear_fault  input  1  one-cycle operator clear request.
- lamp1  output  3  road 1 lamp drive.
- lamp2  output  3  road 2 lamp drive.
- fault  output  1  high while in FAULT or RECOVER.
- fault_code  output  3  latched cause: 0 none, 1 ILLEGAL, 2 CONFLICT, 3 BAD_SEQ, 4 STUCK.
- fault_count  output  8  present only with FAULT_COUNT_EN.

Behaviour:
- Reset state (all registers asynchronous on rst_n low):
  - lamp1 = lamp2 = 3'b001; fault = 0; fault_code = 0.
  - state = NORMAL; sample and previous registers = RED/RED.
  - dwell = 0; hold = 0; blink = 1.
- Input stage: road1_in/road2_in registered every cycle (cur). prev holds last cycle's cur.
- Latency: in NORMAL, lamp outputs = cur. An input appears on the lamps 2 cycles after it is applied (input register + output register).
- Checks run in NORMAL only, every cycle, on cur/prev:
  - ILLEGAL: either road code not in {001,010,100}.
  - CONFLICT: neither road is RED.
  - BAD_SEQ: either road goes RED->GREEN or GREEN->RED. Legal transitions are R->Y, Y->G, G->Y, Y->R, and no change.
  - STUCK: dwell reaches MAX_DWELL while either road is non-RED.
- Simultaneous violations: priority ILLEGAL > CONFLICT > BAD_SEQ > STUCK; only the highest is latched.
- Dwell counter:
  - Cleared on any change cur != prev; a change wins over a tick in the same cycle.
  - Otherwise increments on tick while any road is non-RED.
  - Held at 0 while both roads are RED. Saturates at MAX_DWELL.
- NORMAL -> FAULT on any violation:
  - fault = 1 and fault_code latched, both at the next clock edge.
  - Lamps switch to flashing red the same edge.
- FAULT:
  - lamp1 = lamp2 = {2'b00, blink}. blink toggles on each tick and is set to 1 on FAULT entry.
  - Checks disabled; fault_code held.
  - clear_fault -> RECOVER (hold = 0). clear_fault in NORMAL or RECOVER is ignored.
- RECOVER:
  - Lamps solid RED on both roads; fault stays 1.
  - On tick with cur both RED: hold++. Any cycle with cur not both RED: hold = 0.
  - hold == HOLD_TICKS -> NORMAL; fault = 0, fault_code = 0, dwell = 0, prev = cur. Checks resume the following cycle.
- Reset asserted mid-operation in any state returns immediately to the reset values.

Optional Feature:
- Macro: FAULT_COUNT_EN.
- Defined:
  - Port fault_count[7:0] exists; reset 0.
  - Increments on each NORMAL->FAULT entry; saturates at 255.
  - Not cleared by RECOVER, only by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Legal cycle: drive both-RED, then road1 Y, G, Y, R, then road2 Y, G, Y, R, each held 2-10 ticks -> lamps track inputs with 2-cycle latency; fault stays 0 throughout.
- Conflict: road1=GREEN and road2=YELLOW together -> fault=1, fault_code=2 next edge; lamps = 001/000 alternating on each tick.
- Bad sequence and priority:
  - road1 RED->GREEN with road2 RED -> fault_code=3.
  - road1 = 3'b011 in the same cycle as a conflict -> fault_code=1.
- Stuck: road1 GREEN held 15 ticks with no change -> fault_code=4 on the 15th tick; a change on the 14th tick restarts dwell, so no fault.
- Recovery:
  - clear_fault with inputs both RED for 3 ticks -> fault=0 and fault_code=0 after the 3rd tick.
  - A non-red input at tick 2 restarts hold; clear_fault in NORMAL has no effect.
- Reset and counter:
  - rst_n pulsed low in FAULT -> lamps 001/001, fault=0 immediately.
  - With FAULT_COUNT_EN, three fault entries -> fault_count=3, and it stays 3 after recovery.
